bit_deserializer: RTL and testbench

Serial-to-parallel collector that sits directly upstream of the parameterised N-way AND reduction (`and_nway`). It accepts one bit per handshake, assembles NB_IN-bit words LSB-first, and presents each completed word on a held output register with a valid/ready handshake. A one-word skid stage (the fill register) lets collection of the next word continue while the previous word waits to be consumed.

---
 rtl/bit_deserializer_if.sv | 25 ++
 rtl/bit_deserializer.sv | 78 +++++++
 tb/tb_bit_deserializer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/bit_deserializer_if.sv
// Handshake bundle between a serial bit source, the deserializer and the word consumer.
// Source/consumer side uses master; the deserializer uses slave.
interface bit_deserializer_if #(
    parameter int NB_IN = 8,
    parameter int CW    = $clog2(NB_IN + 1)
);
    logic             in_bit;
    logic             in_valid;
    logic             in_ready;
    logic             clear;
    logic [NB_IN-1:0] out_vec;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    fill_count;

    modport master (
        output in_bit, in_valid, clear, out_ready,
        input  in_ready, out_vec, out_valid, fill_count
    );

    modport slave (
        input  in_bit, in_valid, clear, out_ready,
        output in_ready, out_vec, out_valid, fill_count
    );
endinterface

// File: rtl/bit_deserializer.sv
// Serial-to-parallel collector: LSB-first NB_IN-bit words, one-word fill (skid) register
// ahead of a held output register. Handshakes: a transfer happens on an edge where valid && ready.
module bit_deserializer #(
    parameter int NB_IN = 8,
    parameter int CW    = $clog2(NB_IN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    bit_deserializer_if.slave bus
);
    logic [NB_IN-1:0] fill_q, fill_n;
    logic [CW-1:0]    count_q, count_n;
    logic [NB_IN-1:0] vec_q, vec_n;
    logic             valid_q, valid_n;
    logic             stalled;
    logic             slot_free;

    // fill_count is the fill state: 0 EMPTY, 1..NB_IN-1 PARTIAL, NB_IN STALLED.
    assign stalled   = (count_q == CW'(NB_IN));
    assign slot_free = !valid_q || bus.out_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q  <= '0;
            count_q <= '0;
            vec_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            fill_q  <= fill_n;
            count_q <= count_n;
            vec_q   <= vec_n;
            valid_q <= valid_n;
        end
    end

    // Next-state logic; clear outranks both the stall transfer and completion.
    always_comb begin
        fill_n  = fill_q;
        count_n = count_q;
        vec_n   = vec_q;
        valid_n = valid_q;
        if (valid_q && bus.out_ready) valid_n = 1'b0;
        if (bus.clear) begin
            count_n = '0;
        end else if (stalled) begin
            if (slot_free) begin
                vec_n   = fill_q;
                valid_n = 1'b1;
                count_n = '0;
            end
        end else if (bus.in_valid) begin
            if (count_q == CW'(NB_IN - 1)) begin
                if (slot_free) begin
                    vec_n   = {bus.in_bit, fill_q[NB_IN-2:0]};
                    valid_n = 1'b1;
                    count_n = '0;
                end else begin
                    fill_n[NB_IN-1] = bus.in_bit;
                    count_n         = CW'(NB_IN);
                end
            end else begin
                for (int i = 0; i < NB_IN - 1; i++) begin
                    if (count_q == CW'(i)) fill_n[i] = bus.in_bit;
                end
                count_n = count_q + 1'b1;
            end
        end
    end

    // Outputs are pure decodes of registered state.
    always_comb begin
        bus.in_ready   = !stalled;
        bus.out_vec    = vec_q;
        bus.out_valid  = valid_q;
        bus.fill_count = count_q;
    end
endmodule

// File: tb/tb_bit_deserializer.sv
// Directed bench for bit_deserializer at NB_IN=8 and NB_IN=3 with hand-computed expectations.
module tb_bit_deserializer;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [7:0] exp_q[$];

    bit_deserializer_if #(.NB_IN(8)) bus8 ();
    bit_deserializer_if #(.NB_IN(3)) bus3 ();

    bit_deserializer #(.NB_IN(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
    bit_deserializer #(.NB_IN(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Driver tasks: inputs change 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_bit(input logic b);
        bus8.in_valid = 1'b1;
        bus8.in_bit   = b;
        tick();
        bus8.in_valid = 1'b0;
    endtask

    task automatic push_word(input logic [7:0] w);
        for (int k = 0; k < 8; k++) push_bit(w[k]);
    endtask

    task automatic push_bit3(input logic b);
        bus3.in_valid = 1'b1;
        bus3.in_bit   = b;
        tick();
        bus3.in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n) check("fc3_max", 32'(bus3.fill_count <= 2'd3), 32'd1);
    end

    initial begin
        logic [7:0] w;
        logic [7:0] exp_w;
        logic [2:0] w3;
        checks = 0;
        errors = 0;
        bus8.in_bit = 0; bus8.in_valid = 0; bus8.clear = 0; bus8.out_ready = 0;
        bus3.in_bit = 0; bus3.in_valid = 0; bus3.clear = 0; bus3.out_ready = 1;
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_out_vec", 32'(bus8.out_vec), 32'h0);
        check("rst_out_valid", 32'(bus8.out_valid), 32'd0);
        check("rst_fill_count", 32'(bus8.fill_count), 32'd0);
        check("rst_in_ready", 32'(bus8.in_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        // Exhaustive sweep, consumer always ready
        bus8.out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            w = 8'(i);
            exp_q.push_back(w);
            push_word(w);
            exp_w = exp_q.pop_front();
            check("sweep_valid", 32'(bus8.out_valid), 32'd1);
            check("sweep_vec", 32'(bus8.out_vec), 32'(exp_w));
            check("sweep_and8", 32'(&bus8.out_vec), 32'(i == 255));
        end
        tick();
        check("sweep_drain_valid", 32'(bus8.out_valid), 32'd0);
        check("sweep_vec_held", 32'(bus8.out_vec), 32'hFF);

        // Back-pressure: 0xA5 held, 0x3C stalls in the fill register
        bus8.out_ready = 1'b0;
        push_word(8'hA5);
        check("bp_a5_vec", 32'(bus8.out_vec), 32'hA5);
        check("bp_a5_fill", 32'(bus8.fill_count), 32'd0);
        push_word(8'h3C);
        check("bp_stall_fill", 32'(bus8.fill_count), 32'd8);
        check("bp_stall_ready", 32'(bus8.in_ready), 32'd0);
        check("bp_stall_vec", 32'(bus8.out_vec), 32'hA5);
        check("bp_stall_valid", 32'(bus8.out_valid), 32'd1);
        tick();
        check("bp_still_stalled", 32'(bus8.fill_count), 32'd8);
        bus8.out_ready = 1'b1;
        tick();
        bus8.out_ready = 1'b0;
        check("bp_move_vec", 32'(bus8.out_vec), 32'h3C);
        check("bp_move_valid", 32'(bus8.out_valid), 32'd1);
        check("bp_move_fill", 32'(bus8.fill_count), 32'd0);
        check("bp_ready_back", 32'(bus8.in_ready), 32'd1);

        // Consume and complete in the same cycle: no bubble
        bus8.out_ready = 1'b1;
        tick();
        bus8.out_ready = 1'b0;
        check("sim_drain", 32'(bus8.out_valid), 32'd0);
        push_word(8'h0F);
        check("sim_0f_vec", 32'(bus8.out_vec), 32'h0F);
        w = 8'hF0;
        for (int k = 0; k < 8; k++) begin
            bus8.out_ready = (k == 7);
            push_bit(w[k]);
            check("sim_valid_high", 32'(bus8.out_valid), 32'd1);
        end
        bus8.out_ready = 1'b0;
        check("sim_f0_vec", 32'(bus8.out_vec), 32'hF0);
        check("sim_f0_fill", 32'(bus8.fill_count), 32'd0);

        // clear mid-word drops the offered bit and keeps the output register
        bus8.out_ready = 1'b1;
        tick();
        bus8.out_ready = 1'b0;
        check("clr_consumed", 32'(bus8.out_valid), 32'd0);
        check("clr_vec_kept", 32'(bus8.out_vec), 32'hF0);
        push_bit(1'b1);
        push_bit(1'b0);
        push_bit(1'b1);
        check("clr_partial_fill", 32'(bus8.fill_count), 32'd3);
        bus8.clear = 1'b1;
        bus8.in_valid = 1'b1;
        bus8.in_bit = 1'b1;
        check("clr_in_ready", 32'(bus8.in_ready), 32'd1);
        tick();
        bus8.clear = 1'b0;
        bus8.in_valid = 1'b0;
        check("clr_fill", 32'(bus8.fill_count), 32'd0);
        check("clr_vec", 32'(bus8.out_vec), 32'hF0);
        check("clr_valid", 32'(bus8.out_valid), 32'd0);
        push_word(8'h81);
        check("clr_81_vec", 32'(bus8.out_vec), 32'h81);
        check("clr_81_valid", 32'(bus8.out_valid), 32'd1);

        // Asynchronous reset while stalled
        push_word(8'h77);
        check("ar_stalled", 32'(bus8.fill_count), 32'd8);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(bus8.out_valid), 32'd0);
        check("ar_vec", 32'(bus8.out_vec), 32'h0);
        check("ar_fill", 32'(bus8.fill_count), 32'd0);
        check("ar_ready", 32'(bus8.in_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        bus8.out_ready = 1'b1;
        push_word(8'h96);
        check("ar_first_word", 32'(bus8.out_vec), 32'h96);
        bus8.out_ready = 1'b0;

        // NB_IN=3 instance: 0b101 then 0b111
        w3 = 3'b101;
        for (int k = 0; k < 3; k++) push_bit3(w3[k]);
        check("n3_w0_valid", 32'(bus3.out_valid), 32'd1);
        check("n3_w0_vec", 32'(bus3.out_vec), 32'd5);
        check("n3_w0_and", 32'(&bus3.out_vec), 32'd0);
        w3 = 3'b111;
        for (int k = 0; k < 3; k++) push_bit3(w3[k]);
        check("n3_w1_vec", 32'(bus3.out_vec), 32'd7);
        check("n3_w1_and", 32'(&bus3.out_vec), 32'd1);
        check("n3_fill", 32'(bus3.fill_count), 32'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
